usb_crc_engine: RTL and testbench
=================================

// Module: usb_crc_engine
// PURPOSE
//  Sequential, parametrised USB CRC generator/checker; replaces fixed 11-bit combinational CRC5.
//  Accumulates CRC5 (tokens) or CRC16 (data packets) over a stream of DIN_W-bit words, LSB first.
//  Produces the transmit CRC and a residual-based receive check.
//  Sits between the USB PHY serialiser/deserialiser and the packet engine.
// PARAMETERS
//  CRC_W   5        CRC width; 5 or 16 only
//  POLY    5'h05    generator polynomial, implicit x^CRC_W term (16'h8005 for CRC16)
//  RESID   5'h0C    good-packet residual (16'h800D for CRC16)
//  DIN_W   8        bits consumed per accepted word; 1..16
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              async reset, active low
//  start      in   1              begin new packet: register <= all ones, state -> ACCUM
//  din_valid  in   1              din carries a word
//  din        in   DIN_W          data bits, din[0] processed first
//  din_nbits  in   $clog2(DIN_W+1) valid bits in din (1..DIN_W), LSBs; 0 treated as DIN_W
//  din_last   in   1              final word of packet
//  din_ready  out  1              engine accepts a word this cycle
//  crc_out    out  CRC_W          ~register; value to transmit, MSB sent first
//  crc_valid  out  1              1-cycle pulse: crc_out/crc_ok final
//  crc_ok     out  1              register == RESID at packet end (receive check)
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, register all ones, crc_out 0, crc_valid 0, crc_ok 0, din_ready 0, busy 0.
//  Per bit b: fb = b ^ r[CRC_W-1]; r = {r[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//  FSM: IDLE -start-> ACCUM; ACCUM -(din_valid & din_last)-> DONE; DONE -> IDLE next cycle.
//  ACCUM: din_ready=1; word accepted when din_valid & din_ready; all din_nbits bits folded same cycle.
//  DONE: crc_valid=1 for exactly one cycle; crc_out and crc_ok held until next start.
//  Latency: crc_valid asserts the cycle after the accepting din_last edge.
//  start in any state (incl. ACCUM/DONE mid-packet) aborts, re-inits register, -> ACCUM; din same cycle ignored.
//  din_valid in IDLE/DONE ignored, din_ready=0 there. Zero-word packet: start then din_last with din_nbits
//   counted -> use START_EMPTY path: start & din_last together => DONE, crc_out = ~all_ones = 0.
//  crc_ok compares raw register (pre-inversion) to RESID; crc_out irrelevant on receive.
//  Async reset mid-packet: immediate return to reset values; no partial result emitted.
// CONFIGURATION
//  USB_CRC_TXSHIFT_EN defined: adds ports tx_bit(out 1), tx_bit_valid(out 1), tx_bit_ready(in 1);
//   state SHIFT after DONE emits crc_out MSB..LSB, one bit per tx_bit_valid&tx_bit_ready, bit counter
//   CRC_W-1..0; IDLE after last bit; busy high through SHIFT; start aborts SHIFT. tx_* reset to 0.
//  Undefined: no tx_* ports, no SHIFT state; DONE -> IDLE directly.
// STRUCTURE
//  usb_pkg: state enum (IDLE, ACCUM, DONE, SHIFT), CRC5/CRC16 POLY and RESID constants, PID codes.
//  Sub-module usb_crc_step: combinational fold of up to DIN_W bits (register, din, nbits) -> next register.
//  Top: FSM, register, output regs, optional shift counter.
// TESTING
//  CRC5, DIN_W=11: token addr=7'h15 endp=4'hE (din=11'h715 LSB first) -> crc_out=5'h17, crc_valid 1 cycle.
//  CRC5 check: same 11 bits + CRC 5'h17 (16 bits) -> crc_ok=1; flip any one bit -> crc_ok=0.
//  CRC16, DIN_W=8: start&din_last with zero-length packet -> crc_out=16'h0000.
//  CRC16 bytes 00 01 02 03 then computed CRC bytes (low first) -> crc_ok=1 at register 16'h800D.
//  start pulsed mid-packet after 2 bytes, then fresh packet -> result equals clean single-packet result.
//  TXSHIFT_EN: crc_out=5'h17 shifts 1,0,1,1,1 with tx_bit_ready stalled 2 cycles mid-way; rst_n low
//   mid-ACCUM -> all outputs 0 next edge-free cycle, busy 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: engine state codes, CRC5/CRC16 polynomials and residuals, PID codes.
package usb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    localparam logic [4:0]  CRC5_POLY   = 5'h05;
    localparam logic [4:0]  CRC5_RESID  = 5'h0C;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_RESID = 16'h800D;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    // Data packets carry CRC16; tokens carry CRC5; handshakes carry none.
    function automatic logic pid_uses_crc16(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_crc_step.sv
// Combinational CRC fold of up to DIN_W bits, din[0] first; nbits of 0 means all DIN_W bits.
module usb_crc_step #(
    parameter int unsigned      CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 5'h05,
    parameter int unsigned      DIN_W = 8
) (
    input  logic [CRC_W-1:0]             crc,
    input  logic [DIN_W-1:0]             din,
    input  logic [$clog2(DIN_W+1)-1:0]   nbits,
    output logic [CRC_W-1:0]             crc_next
);

    always_comb begin
        int unsigned      count;
        logic [CRC_W-1:0] r;
        count = (nbits == '0) ? DIN_W : 32'(nbits);
        r     = crc;
        for (int unsigned i = 0; i < DIN_W; i++) begin
            if (i < count) begin
                if (din[i] ^ r[CRC_W-1]) begin
                    r = {r[CRC_W-2:0], 1'b0} ^ POLY;
                end else begin
                    r = {r[CRC_W-2:0], 1'b0};
                end
            end
        end
        crc_next = r;
    end

endmodule

// File: rtl/usb_crc_engine.sv
// Sequential USB CRC5/CRC16 generator and residual checker over DIN_W-bit words, LSB first.
// Define USB_CRC_TXSHIFT_EN to add a serial MSB-first CRC shifter (tx_bit/tx_bit_valid/tx_bit_ready).
module usb_crc_engine
    import usb_pkg::*;
#(
    parameter int unsigned      CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = (CRC_W == 16) ? CRC_W'(CRC16_POLY) : CRC_W'(CRC5_POLY),
    parameter logic [CRC_W-1:0] RESID = (CRC_W == 16) ? CRC_W'(CRC16_RESID) : CRC_W'(CRC5_RESID),
    parameter int unsigned      DIN_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           din_valid,
    input  logic [DIN_W-1:0]               din,
    input  logic [$clog2(DIN_W+1)-1:0]     din_nbits,
    input  logic                           din_last,
    output logic                           din_ready,
    output logic [CRC_W-1:0]               crc_out,
    output logic                           crc_valid,
    output logic                           crc_ok,
`ifdef USB_CRC_TXSHIFT_EN
    output logic                           tx_bit,
    output logic                           tx_bit_valid,
    input  logic                           tx_bit_ready,
`endif
    output logic                           busy
);

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_step;
    logic             ok_q, ok_d;

`ifdef USB_CRC_TXSHIFT_EN
    localparam int unsigned CNT_W = $clog2(CRC_W);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    usb_crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .DIN_W (DIN_W)
    ) u_step (
        .crc      (crc_q),
        .din      (din),
        .nbits    (din_nbits),
        .crc_next (crc_step)
    );

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        ok_d    = ok_q;
`ifdef USB_CRC_TXSHIFT_EN
        cnt_d   = cnt_q;
`endif
        if (start) begin
            // start overrides everything; start with din_last is an empty packet.
            crc_d   = '1;
            ok_d    = 1'b0;
            state_d = din_last ? ST_DONE : ST_ACCUM;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ACCUM: begin
                    if (din_valid) begin
                        crc_d = crc_step;
                        if (din_last) begin
                            ok_d    = (crc_step == RESID);
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
`ifdef USB_CRC_TXSHIFT_EN
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(CRC_W - 1);
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef USB_CRC_TXSHIFT_EN
                ST_SHIFT: begin
                    if (tx_bit_ready) begin
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= '1;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            ok_q    <= ok_d;
        end
    end

`ifdef USB_CRC_TXSHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tx_bit_valid = (state_q == ST_SHIFT);
    assign tx_bit       = (state_q == ST_SHIFT) & crc_out[cnt_q];
`endif

    // Register only moves while accumulating, so its inverse holds the result until next start.
    assign crc_out   = ~crc_q;
    assign crc_ok    = ok_q;
    assign crc_valid = (state_q == ST_DONE);
    assign din_ready = (state_q == ST_ACCUM);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_crc_engine.sv
// Scoreboard bench for usb_crc_engine: a CRC5 (DIN_W=11) and a CRC16 (DIN_W=8) instance.
module tb_usb_crc_engine;

    typedef struct packed {
        logic [15:0] crc;
        logic        ok;
        logic        chk_crc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q5[$];
    exp_t q16[$];

    // CRC5 instance signals
    logic        c5_start, c5_din_valid, c5_last;
    logic [10:0] c5_din;
    logic [3:0]  c5_nbits;
    logic        c5_ready, c5_valid, c5_ok, c5_busy;
    logic [4:0]  c5_crc;

    // CRC16 instance signals
    logic        c16_start, c16_din_valid, c16_last;
    logic [7:0]  c16_din;
    logic [3:0]  c16_nbits;
    logic        c16_ready, c16_valid, c16_ok, c16_busy;
    logic [15:0] c16_crc;

`ifdef USB_CRC_TXSHIFT_EN
    logic c5_tx_bit, c5_tx_valid, c5_tx_ready;
    logic c16_tx_bit, c16_tx_valid;
`endif

    usb_crc_engine #(
        .CRC_W (5),
        .POLY  (5'h05),
        .RESID (5'h0C),
        .DIN_W (11)
    ) u_crc5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (c5_start),
        .din_valid    (c5_din_valid),
        .din          (c5_din),
        .din_nbits    (c5_nbits),
        .din_last     (c5_last),
        .din_ready    (c5_ready),
        .crc_out      (c5_crc),
        .crc_valid    (c5_valid),
        .crc_ok       (c5_ok),
`ifdef USB_CRC_TXSHIFT_EN
        .tx_bit       (c5_tx_bit),
        .tx_bit_valid (c5_tx_valid),
        .tx_bit_ready (c5_tx_ready),
`endif
        .busy         (c5_busy)
    );

    usb_crc_engine #(
        .CRC_W (16),
        .POLY  (16'h8005),
        .RESID (16'h800D),
        .DIN_W (8)
    ) u_crc16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (c16_start),
        .din_valid    (c16_din_valid),
        .din          (c16_din),
        .din_nbits    (c16_nbits),
        .din_last     (c16_last),
        .din_ready    (c16_ready),
        .crc_out      (c16_crc),
        .crc_valid    (c16_valid),
        .crc_ok       (c16_ok),
`ifdef USB_CRC_TXSHIFT_EN
        .tx_bit       (c16_tx_bit),
        .tx_bit_valid (c16_tx_valid),
        .tx_bit_ready (1'b1),
`endif
        .busy         (c16_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic c5_start_pkt();
        c5_start = 1'b1;
        tick();
        c5_start = 1'b0;
    endtask

    task automatic c5_word(input logic [10:0] d, input logic [3:0] n, input logic last);
        c5_din_valid = 1'b1;
        c5_din       = d;
        c5_nbits     = n;
        c5_last      = last;
        tick();
        c5_din_valid = 1'b0;
        c5_last      = 1'b0;
        if (last) check("c5_valid_latency", 32'(c5_valid), 32'h1);
    endtask

    task automatic c16_start_pkt(input logic last);
        c16_start = 1'b1;
        c16_last  = last;
        tick();
        c16_start = 1'b0;
        c16_last  = 1'b0;
        if (last) check("c16_empty_valid_latency", 32'(c16_valid), 32'h1);
    endtask

    task automatic c16_byte(input logic [7:0] d, input logic last);
        c16_din_valid = 1'b1;
        c16_din       = d;
        c16_nbits     = last ? 4'd0 : 4'd8;
        c16_last      = last;
        tick();
        c16_din_valid = 1'b0;
        c16_last      = 1'b0;
        if (last) check("c16_valid_latency", 32'(c16_valid), 32'h1);
    endtask

    // Monitors: pop one expectation per crc_valid cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (c5_valid) begin
                if (q5.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL c5_unexpected_valid: got crc_valid=1, required 0");
                end else begin
                    e = q5.pop_front();
                    if (e.chk_crc) check("c5_crc_out", 32'(c5_crc), 32'(e.crc));
                    check("c5_crc_ok", 32'(c5_ok), 32'(e.ok));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (c16_valid) begin
                if (q16.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL c16_unexpected_valid: got crc_valid=1, required 0");
                end else begin
                    e = q16.pop_front();
                    if (e.chk_crc) check("c16_crc_out", 32'(c16_crc), 32'(e.crc));
                    check("c16_crc_ok", 32'(c16_ok), 32'(e.ok));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        c5_start = 1'b0; c5_din_valid = 1'b0; c5_last = 1'b0; c5_din = '0; c5_nbits = '0;
        c16_start = 1'b0; c16_din_valid = 1'b0; c16_last = 1'b0; c16_din = '0; c16_nbits = '0;
`ifdef USB_CRC_TXSHIFT_EN
        c5_tx_ready = 1'b1;
`endif
        idle(2);
        check("c5_rst_crc_out", 32'(c5_crc), 32'h0);
        check("c5_rst_valid", 32'(c5_valid), 32'h0);
        check("c5_rst_ok", 32'(c5_ok), 32'h0);
        check("c5_rst_ready", 32'(c5_ready), 32'h0);
        check("c5_rst_busy", 32'(c5_busy), 32'h0);
        check("c16_rst_crc_out", 32'(c16_crc), 32'h0);
        check("c16_rst_valid", 32'(c16_valid), 32'h0);
        check("c16_rst_busy", 32'(c16_busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // CRC5 transmit: token addr 15h endp Eh, nbits 0 means all 11 bits.
        q5.push_back('{crc: 16'h0017, ok: 1'b0, chk_crc: 1'b1});
        c5_start_pkt();
        check("c5_accum_ready", 32'(c5_ready), 32'h1);
        check("c5_accum_busy", 32'(c5_busy), 32'h1);
        c5_word(11'h715, 4'd0, 1'b1);
        idle(8);
        check("c5_hold_crc_out", 32'(c5_crc), 32'h17);
        check("c5_idle_busy", 32'(c5_busy), 32'h0);

        // CRC5 receive: token bits then CRC MSB first (5'h17 reversed = 5'h1D), residual 0x0C.
        q5.push_back('{crc: 16'h0013, ok: 1'b1, chk_crc: 1'b1});
        c5_start_pkt();
        c5_word(11'h715, 4'd11, 1'b0);
        c5_word(11'h01D, 4'd5, 1'b1);
        idle(8);

        // Single-bit error must fail the check.
        q5.push_back('{crc: 16'h0000, ok: 1'b0, chk_crc: 1'b0});
        c5_start_pkt();
        c5_word(11'h714, 4'd11, 1'b0);
        c5_word(11'h01D, 4'd5, 1'b1);
        idle(8);

        // CRC16 empty packet.
        q16.push_back('{crc: 16'h0000, ok: 1'b0, chk_crc: 1'b1});
        c16_start_pkt(1'b1);
        idle(8);

        // CRC16 transmit of 00 01 02 03.
        q16.push_back('{crc: 16'hF75E, ok: 1'b0, chk_crc: 1'b1});
        c16_start_pkt(1'b0);
        c16_byte(8'h00, 1'b0);
        c16_byte(8'h01, 1'b0);
        c16_byte(8'h02, 1'b0);
        c16_byte(8'h03, 1'b1);
        idle(8);

        // CRC16 receive with CRC bytes EF 7A: residual 800D, crc_out = ~800D.
        q16.push_back('{crc: 16'h7FF2, ok: 1'b1, chk_crc: 1'b1});
        c16_start_pkt(1'b0);
        c16_byte(8'h00, 1'b0);
        c16_byte(8'h01, 1'b0);
        c16_byte(8'h02, 1'b0);
        c16_byte(8'h03, 1'b0);
        c16_byte(8'hEF, 1'b0);
        c16_byte(8'h7A, 1'b1);
        idle(8);

        // Abort after two bytes, then a clean packet.
        q16.push_back('{crc: 16'hF75E, ok: 1'b0, chk_crc: 1'b1});
        c16_start_pkt(1'b0);
        c16_byte(8'h00, 1'b0);
        c16_byte(8'h01, 1'b0);
        c16_start_pkt(1'b0);
        c16_byte(8'h00, 1'b0);
        c16_byte(8'h01, 1'b0);
        c16_byte(8'h02, 1'b0);
        c16_byte(8'h03, 1'b1);
        idle(8);

        // din_valid while idle is ignored.
        c16_din_valid = 1'b1;
        c16_din       = 8'hFF;
        c16_last      = 1'b1;
        tick();
        check("c16_idle_ready", 32'(c16_ready), 32'h0);
        check("c16_idle_busy", 32'(c16_busy), 32'h0);
        c16_din_valid = 1'b0;
        c16_last      = 1'b0;
        idle(2);
        check("c16_idle_hold_crc", 32'(c16_crc), 32'hF75E);

`ifdef USB_CRC_TXSHIFT_EN
        begin
            logic [4:0] exp_bits;
            exp_bits = 5'h17;
            q5.push_back('{crc: 16'h0017, ok: 1'b0, chk_crc: 1'b1});
            c5_start_pkt();
            c5_word(11'h715, 4'd0, 1'b1);
            check("tx_done_valid", 32'(c5_tx_valid), 32'h0);
            tick();
            for (int i = 0; i < 5; i++) begin
                check("tx_bit_valid", 32'(c5_tx_valid), 32'h1);
                check("tx_bit", 32'(c5_tx_bit), 32'(exp_bits[4-i]));
                if (i == 2) begin
                    c5_tx_ready = 1'b0;
                    repeat (2) begin
                        tick();
                        check("tx_stall_valid", 32'(c5_tx_valid), 32'h1);
                        check("tx_stall_bit", 32'(c5_tx_bit), 32'(exp_bits[4-i]));
                    end
                    c5_tx_ready = 1'b1;
                end
                tick();
            end
            check("tx_end_valid", 32'(c5_tx_valid), 32'h0);
            check("tx_end_busy", 32'(c5_busy), 32'h0);
            idle(2);
        end
`endif

        // Async reset mid-packet: outputs drop without waiting for a clock edge.
        c16_start_pkt(1'b0);
        c16_byte(8'h00, 1'b0);
        c16_din_valid = 1'b1;
        c16_din       = 8'h01;
        c16_nbits     = 4'd8;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_crc_out", 32'(c16_crc), 32'h0);
        check("arst_valid", 32'(c16_valid), 32'h0);
        check("arst_ok", 32'(c16_ok), 32'h0);
        check("arst_ready", 32'(c16_ready), 32'h0);
        check("arst_busy", 32'(c16_busy), 32'h0);
        c16_din_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(4);
        check("arst_after_busy", 32'(c16_busy), 32'h0);

        check("q5_drained", 32'(q5.size()), 32'h0);
        check("q16_drained", 32'(q16.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
